// File: rtl/time_set_ctrl_pkg.sv
// time_set_pkg: shared types and constants for the front-panel time-set
// controller and the wall-clock timer it feeds.
//   time_val_t   6-bit binary hours/minutes value
//   state_e      set-mode FSM states
//   FIELD_*      field-select encodings seen by the display stage
//   wrap_inc     +1 with wrap to 0 past the field maximum
//   clamp_val    out-of-range live values become 0 at capture
package time_set_pkg;

  typedef logic [5:0] time_val_t;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    EDIT_H = 2'b01,
    EDIT_M = 2'b10
  } state_e;

  localparam logic [1:0] FIELD_NONE    = 2'b00;
  localparam logic [1:0] FIELD_HOURS   = 2'b01;
  localparam logic [1:0] FIELD_MINUTES = 2'b10;

  localparam time_val_t HOURS_MAX   = 6'd23;
  localparam time_val_t MINUTES_MAX = 6'd59;

  localparam int BTN_MODE = 0;
  localparam int BTN_INC  = 1;
  localparam int NUM_BTN  = 2;

  // Wrap is a compare against the maximum, never a modulo.
  function automatic time_val_t wrap_inc(input time_val_t v, input time_val_t max);
    return (v >= max) ? '0 : v + 6'd1;
  endfunction

  function automatic time_val_t clamp_val(input time_val_t v, input time_val_t max);
    return (v > max) ? '0 : v;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: front-panel / timer / display bundle around the
// time-set controller.
//   btn_mode_n, btn_inc_n  raw active-low buttons
//   cur_hours, cur_minutes live time from the timer
//   set_hours, set_minutes shadow time, valid when load=1
//   load                   one-cycle load strobe to the timer
//   field, blink           edit-field highlight for the display
// Modports: master = controller, slave = panel/timer/display side.
interface time_set_ctrl_if;
  import time_set_pkg::*;

  logic       btn_mode_n;
  logic       btn_inc_n;
  time_val_t  cur_hours;
  time_val_t  cur_minutes;
  time_val_t  set_hours;
  time_val_t  set_minutes;
  logic       load;
  logic [1:0] field;
  logic       blink;

  modport master (
    input  btn_mode_n, btn_inc_n, cur_hours, cur_minutes,
    output set_hours, set_minutes, load, field, blink
  );

  modport slave (
    output btn_mode_n, btn_inc_n, cur_hours, cur_minutes,
    input  set_hours, set_minutes, load, field, blink
  );

endinterface

// File: rtl/time_set_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer + stability debouncer for one raw
// active-low push-button.
//   clk, rst   clock, async active-low reset
//   btn_n      raw button, asynchronous to clk
//   level      debounced state, 1 = pressed
//   press      one-cycle pulse on released->pressed of level
// Param DEBOUNCE_CYCLES: consecutive differing samples needed to accept.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  // Synchronizer carries the pressed sense (inverted raw) so reset = released.
  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], ~btn_n};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // Last differing sample of the window: accept it.
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: front-panel time-setting controller upstream of the
// wall-clock timer. MODE steps RUN -> EDIT_H -> EDIT_M -> RUN (load),
// INC bumps the field being edited.
//   clk, rst  clock, async active-low reset
//   bus       time_set_ctrl_if.master (buttons, live time, set time,
//             load strobe, field select, blink)
// Optional build macro TIME_SET_AUTOREPEAT_EN: holding INC in an edit
// state repeats increments after REPEAT_DELAY, then every REPEAT_RATE.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 12500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic           clk,
  input  logic           rst,
  time_set_ctrl_if.master bus
);

  localparam int BW = $clog2(BLINK_CYCLES + 1);

  logic [NUM_BTN-1:0] btn_n;
  logic [NUM_BTN-1:0] lvl;
  logic [NUM_BTN-1:0] prs;

  assign btn_n[BTN_MODE] = bus.btn_mode_n;
  assign btn_n[BTN_INC]  = bus.btn_inc_n;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .btn_n (btn_n[b]),
      .level (lvl[b]),
      .press (prs[b])
    );
  end

  state_e        state;
  time_val_t     sh_h, sh_m;
  logic          load_q;
  logic [1:0]    field_q;
  logic          blink_q;
  logic [BW-1:0] bcnt;

  logic mode_evt, inc_src, inc_evt;
  logic unused_lvl;

  assign mode_evt   = prs[BTN_MODE];
  assign unused_lvl = lvl[BTN_MODE];

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic          rpt_pulse;
  logic          rpt_armed;
  logic [RW-1:0] rcnt;

  // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE; any release,
  // MODE press or return to RUN starts the wait over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_pulse <= 1'b0;
      rpt_armed <= 1'b0;
      rcnt      <= '0;
    end else begin
      rpt_pulse <= 1'b0;
      if (!lvl[BTN_INC] || state == RUN || mode_evt) begin
        rcnt      <= '0;
        rpt_armed <= 1'b0;
      end else if (rcnt == RW'(rpt_armed ? REPEAT_RATE - 1 : REPEAT_DELAY - 1)) begin
        rcnt      <= '0;
        rpt_armed <= 1'b1;
        rpt_pulse <= 1'b1;
      end else begin
        rcnt <= rcnt + RW'(1);
      end
    end
  end

  assign inc_src = prs[BTN_INC] | rpt_pulse;
`else
  logic unused_cfg;
  assign unused_cfg = ^{lvl[BTN_INC], 32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
  assign inc_src    = prs[BTN_INC];
`endif

  // MODE wins a same-cycle collision; INC does nothing in RUN.
  assign inc_evt = inc_src & ~mode_evt & (state != RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      sh_h    <= '0;
      sh_m    <= '0;
      load_q  <= 1'b0;
      field_q <= FIELD_NONE;
      blink_q <= 1'b0;
      bcnt    <= '0;
    end else begin
      load_q <= 1'b0;
      case (state)
        RUN: if (mode_evt) begin
          sh_h    <= clamp_val(bus.cur_hours, HOURS_MAX);
          sh_m    <= clamp_val(bus.cur_minutes, MINUTES_MAX);
          state   <= EDIT_H;
          field_q <= FIELD_HOURS;
        end
        EDIT_H: begin
          if (mode_evt) begin
            state   <= EDIT_M;
            field_q <= FIELD_MINUTES;
          end else if (inc_evt) begin
            sh_h <= wrap_inc(sh_h, HOURS_MAX);
          end
        end
        EDIT_M: begin
          if (mode_evt) begin
            load_q  <= 1'b1;
            state   <= RUN;
            field_q <= FIELD_NONE;
          end else if (inc_evt) begin
            sh_m <= wrap_inc(sh_m, MINUTES_MAX);
          end
        end
        default: begin
          state   <= RUN;
          field_q <= FIELD_NONE;
        end
      endcase

      // Blink restarts visible on every state change and every edit.
      if (state == RUN || mode_evt || inc_evt) begin
        bcnt    <= '0;
        blink_q <= 1'b0;
      end else if (bcnt == BW'(BLINK_CYCLES - 1)) begin
        bcnt    <= '0;
        blink_q <= ~blink_q;
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end
  end

  assign bus.set_hours   = sh_h;
  assign bus.set_minutes = sh_m;
  assign bus.load        = load_q;
  assign bus.field       = field_q;
  assign bus.blink       = blink_q;

endmodule
